// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and QSPI memory channel bundle for mem_bus_arbiter
interface mem_bus_arbiter_if;
   logic        i_read_req, i_read_w, i_read_hw, i_read_valid;
   logic [31:0] i_read_adr;
   logic        d_read_req, d_write_req, d_read_w, d_read_hw, d_write_w, d_write_hw;
   logic [31:0] d_read_adr, d_write_adr, d_write_data;
   logic        d_read_valid, d_write_finish;
   logic        u_read_req, u_write_req, u_read_w, u_write_w;
   logic [31:0] u_read_adr, u_write_adr, u_write_data;
   logic        u_read_valid, u_write_finish;
   logic        read_req, write_req, read_w, read_hw, write_w, write_hw;
   logic [31:0] read_adr, write_adr, write_data;
   logic        read_valid, write_finish;

   modport slave (
      input  i_read_req, i_read_w, i_read_hw, i_read_adr,
      input  d_read_req, d_write_req, d_read_w, d_read_hw, d_write_w, d_write_hw,
      input  d_read_adr, d_write_adr, d_write_data,
      input  u_read_req, u_write_req, u_read_w, u_write_w,
      input  u_read_adr, u_write_adr, u_write_data,
      input  read_valid, write_finish,
      output i_read_valid, d_read_valid, d_write_finish, u_read_valid, u_write_finish,
      output read_req, write_req, read_w, read_hw, write_w, write_hw,
      output read_adr, write_adr, write_data
   );

   modport master (
      output i_read_req, i_read_w, i_read_hw, i_read_adr,
      output d_read_req, d_write_req, d_read_w, d_read_hw, d_write_w, d_write_hw,
      output d_read_adr, d_write_adr, d_write_data,
      output u_read_req, u_write_req, u_read_w, u_write_w,
      output u_read_adr, u_write_adr, u_write_data,
      output read_valid, write_finish,
      input  i_read_valid, d_read_valid, d_write_finish, u_read_valid, u_write_finish,
      input  read_req, write_req, read_w, read_hw, write_w, write_hw,
      input  read_adr, write_adr, write_data
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing the QSPI port among I, D and U requesters
// Optional WAIT timeout with sticky error flag when ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter
`ifdef ARB_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
   input  logic             clk,
   input  logic             rst_n,
   mem_bus_arbiter_if.slave bus,
   output logic             arb_busy,
   output logic             timeout_err
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_WAIT_R = 2'd2;
   localparam logic [1:0] ST_WAIT_W = 2'd3;

   localparam logic [1:0] SRC_I = 2'd0;
   localparam logic [1:0] SRC_D = 2'd1;

   // Slot order: 0 I-rd, 1 D-rd, 2 D-wr, 3 U-rd, 4 U-wr
   logic [4:0]       req, req_w, req_hw;
   logic [4:0][31:0] req_adr, req_data;
   logic [4:0]       pend, clr, accept;
   logic [4:0]       slot_w, slot_hw;
   logic [4:0][31:0] slot_adr, slot_data;

   logic [1:0]  state;
   logic [1:0]  ptr;
   logic [2:0]  owner_slot;
   logic [1:0]  owner_src;
   logic        owner_wr, owner_w, owner_hw;
   logic [31:0] owner_adr, owner_data;

   logic [2:0]  src_pend;
   logic [2:0]  cand;
   logic [1:0]  grant_src;
   logic [2:0]  grant_slot;
   logic        tmo, rd_done, wr_done;

   assign req     = {bus.u_write_req, bus.u_read_req, bus.d_write_req, bus.d_read_req, bus.i_read_req};
   assign req_w   = {bus.u_write_w, bus.u_read_w, bus.d_write_w, bus.d_read_w, bus.i_read_w};
   assign req_hw  = {1'b0, 1'b0, bus.d_write_hw, bus.d_read_hw, bus.i_read_hw};
   assign req_adr = {bus.u_write_adr, bus.u_read_adr, bus.d_write_adr, bus.d_read_adr, bus.i_read_adr};
   assign req_data = {bus.u_write_data, 32'd0, bus.d_write_data, 32'd0, 32'd0};

   assign src_pend = {pend[4] | pend[3], pend[2] | pend[1], pend[0]};

   // Scan from the pointer; iterating backwards lets the nearest pending source win.
   always_comb begin
      grant_src = ptr;
      cand      = 3'd0;
      for (int i = 2; i >= 0; i--) begin
         cand = {1'b0, ptr} + 3'(i);
         if (cand > 3'd2) cand = cand - 3'd3;
         if (src_pend[cand[1:0]]) grant_src = cand[1:0];
      end
      case (grant_src)
         SRC_I:   grant_slot = 3'd0;
         SRC_D:   grant_slot = pend[2] ? 3'd2 : 3'd1;
         default: grant_slot = pend[4] ? 3'd4 : 3'd3;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        tmo_err;

   assign tmo = ((state == ST_WAIT_R) || (state == ST_WAIT_W)) &&
                (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign timeout_err = tmo_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
      end else begin
         if (state == ST_ISSUE) tmo_cnt <= '0;
         else if (state == ST_WAIT_R || state == ST_WAIT_W) tmo_cnt <= tmo_cnt + 16'd1;
         if (tmo) tmo_err <= 1'b1;
      end
   end
`else
   assign tmo         = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign rd_done = (state == ST_WAIT_R) && (bus.read_valid || tmo);
   assign wr_done = (state == ST_WAIT_W) && (bus.write_finish || tmo);
   assign clr     = (rd_done || wr_done) ? (5'b00001 << owner_slot) : 5'b00000;
   // A fresh pulse in the completion cycle of its own slot re-arms it.
   assign accept  = req & (~pend | clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= '0;
         slot_adr  <= '0;
         slot_data <= '0;
         slot_w    <= '0;
         slot_hw   <= '0;
      end else begin
         pend <= (pend & ~clr) | accept;
         for (int k = 0; k < 5; k++) begin
            if (accept[k]) begin
               slot_adr[k]  <= req_adr[k];
               slot_data[k] <= req_data[k];
               slot_w[k]    <= req_w[k];
               slot_hw[k]   <= req_hw[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= SRC_I;
         owner_slot <= '0;
         owner_src  <= SRC_I;
         owner_wr   <= 1'b0;
         owner_w    <= 1'b0;
         owner_hw   <= 1'b0;
         owner_adr  <= '0;
         owner_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|pend) begin
                  state      <= ST_ISSUE;
                  owner_slot <= grant_slot;
                  owner_src  <= grant_src;
                  owner_wr   <= (grant_slot == 3'd2) || (grant_slot == 3'd4);
                  owner_adr  <= slot_adr[grant_slot];
                  owner_data <= slot_data[grant_slot];
                  owner_w    <= slot_w[grant_slot];
                  owner_hw   <= slot_hw[grant_slot];
               end
            end
            ST_ISSUE: state <= owner_wr ? ST_WAIT_W : ST_WAIT_R;
            default: begin
               if (rd_done || wr_done) begin
                  state <= ST_IDLE;
                  ptr   <= (owner_src == 2'd2) ? SRC_I : owner_src + 2'd1;
               end
            end
         endcase
      end
   end

   assign bus.read_req       = (state == ST_ISSUE) && !owner_wr;
   assign bus.write_req      = (state == ST_ISSUE) && owner_wr;
   assign bus.read_adr       = owner_adr;
   assign bus.write_adr      = owner_adr;
   assign bus.read_w         = owner_w;
   assign bus.read_hw        = owner_hw;
   assign bus.write_w        = owner_w;
   assign bus.write_hw       = owner_hw;
   assign bus.write_data     = owner_data;
   assign bus.i_read_valid   = rd_done && (owner_src == 2'd0);
   assign bus.d_read_valid   = rd_done && (owner_src == 2'd1);
   assign bus.u_read_valid   = rd_done && (owner_src == 2'd2);
   assign bus.d_write_finish = wr_done && (owner_src == 2'd1);
   assign bus.u_write_finish = wr_done && (owner_src == 2'd2);
   assign arb_busy           = (state != ST_IDLE) || (|pend);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter with a transaction-level model
module tb_mem_bus_arbiter;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic arb_busy, timeout_err;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bus ();

`ifdef ARB_TIMEOUT_EN
   mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                                .arb_busy(arb_busy), .timeout_err(timeout_err));
`else
   mem_bus_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                        .arb_busy(arb_busy), .timeout_err(timeout_err));
`endif

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   // Transaction-level model: pending slots with their request cycle, RR pointer, one owner.
   bit          m_pend[5];
   int          m_cyc[5];
   logic [31:0] m_adr[5], m_data[5];
   bit          m_w[5], m_hw[5];
   int          m_ptr, m_owner, m_issue, m_last_done;
   bit          m_out, m_terr;

   typedef struct { logic [31:0] adr; bit wr; int cyc; } obs_t;
   obs_t obs[$];
   bit   hammer_i = 1'b0;

   function automatic obs_t ob(int i);
      obs_t none;
      none = '{32'hdeaddead, 1'b0, -1};
      if (i >= 0 && i < obs.size()) return obs[i];
      return none;
   endfunction

   function automatic int src_of(int s);
      return (s == 0) ? 0 : (s <= 2) ? 1 : 2;
   endfunction

   function automatic bit is_wr(int s);
      return (s == 2) || (s == 4);
   endfunction

   function automatic bit elig(int s);
      return m_pend[s] && (m_cyc[s] <= cyc - 2);
   endfunction

   function automatic int pick();
      for (int i = 0; i < 3; i++) begin
         case ((m_ptr + i) % 3)
            0: if (elig(0)) return 0;
            1: begin if (elig(2)) return 2; if (elig(1)) return 1; end
            default: begin if (elig(4)) return 4; if (elig(3)) return 3; end
         endcase
      end
      return -1;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 5; s++) m_pend[s] = 1'b0;
      m_ptr = 0; m_out = 1'b0; m_owner = 0; m_issue = 0;
      m_last_done = -10; m_terr = 1'b0;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("reset_ctrl", {bus.read_req, bus.write_req, bus.i_read_valid, bus.d_read_valid,
                               bus.d_write_finish, bus.u_read_valid, bus.u_write_finish,
                               arb_busy, timeout_err}, 32'd0);
            chk("reset_bus", bus.read_adr | bus.write_adr | bus.write_data, 32'd0);
            model_reset();
         end else begin
            int         g;
            bit         done, tmo_hit, anyp;
            logic [4:0] exp_v, act_v, r;
            anyp = 1'b0;
            for (int s = 0; s < 5; s++) anyp |= m_pend[s];
            chk("arb_busy", arb_busy, m_out || anyp);
            chk("timeout_err", timeout_err, m_terr);
            g = (!m_out && (m_last_done + 2 <= cyc)) ? pick() : -1;
            chk("read_req", bus.read_req, (g >= 0) && !is_wr(g));
            chk("write_req", bus.write_req, (g >= 0) && is_wr(g));
            if (bus.read_req || bus.write_req)
               obs.push_back('{bus.write_req ? bus.write_adr : bus.read_adr, bus.write_req, cyc});
            if (g >= 0) begin
               if (is_wr(g)) begin
                  chk("write_adr", bus.write_adr, m_adr[g]);
                  chk("write_size", {bus.write_w, bus.write_hw}, {m_w[g], m_hw[g]});
                  chk("write_data", bus.write_data, m_data[g]);
               end else begin
                  chk("read_adr", bus.read_adr, m_adr[g]);
                  chk("read_size", {bus.read_w, bus.read_hw}, {m_w[g], m_hw[g]});
               end
               m_out = 1'b1; m_owner = g; m_issue = cyc;
            end else if (m_out) begin
               chk("hold_adr", is_wr(m_owner) ? bus.write_adr : bus.read_adr, m_adr[m_owner]);
            end
            done = 1'b0; tmo_hit = 1'b0;
            if (m_out && cyc > m_issue) begin
`ifdef ARB_TIMEOUT_EN
               tmo_hit = (cyc - m_issue == TMO);
`endif
               done = tmo_hit || (is_wr(m_owner) ? bus.write_finish : bus.read_valid);
            end
            exp_v = 5'd0;
            if (done) exp_v[m_owner] = 1'b1;
            act_v = {bus.u_write_finish, bus.u_read_valid, bus.d_write_finish,
                     bus.d_read_valid, bus.i_read_valid};
            chk("completion", act_v, exp_v);
            if (done) begin
               m_pend[m_owner] = 1'b0;
               m_ptr = (src_of(m_owner) + 1) % 3;
               m_out = 1'b0;
               m_last_done = cyc;
               if (tmo_hit) m_terr = 1'b1;
            end
            r = {bus.u_write_req, bus.u_read_req, bus.d_write_req, bus.d_read_req, bus.i_read_req};
            for (int s = 0; s < 5; s++) begin
               if (r[s] && !m_pend[s]) begin
                  m_pend[s] = 1'b1;
                  m_cyc[s]  = cyc;
                  case (s)
                     0: begin m_adr[s] = bus.i_read_adr;  m_w[s] = bus.i_read_w;  m_hw[s] = bus.i_read_hw;  m_data[s] = 0; end
                     1: begin m_adr[s] = bus.d_read_adr;  m_w[s] = bus.d_read_w;  m_hw[s] = bus.d_read_hw;  m_data[s] = 0; end
                     2: begin m_adr[s] = bus.d_write_adr; m_w[s] = bus.d_write_w; m_hw[s] = bus.d_write_hw; m_data[s] = bus.d_write_data; end
                     3: begin m_adr[s] = bus.u_read_adr;  m_w[s] = bus.u_read_w;  m_hw[s] = 1'b0; m_data[s] = 0; end
                     default: begin m_adr[s] = bus.u_write_adr; m_w[s] = bus.u_write_w; m_hw[s] = 1'b0; m_data[s] = bus.u_write_data; end
                  endcase
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      bus.i_read_req = 0; bus.d_read_req = 0; bus.d_write_req = 0;
      bus.u_read_req = 0; bus.u_write_req = 0;
      bus.read_valid = 0; bus.write_finish = 0;
      if (hammer_i) bus.i_read_req = 1;
   endtask

   task automatic req_i(input logic [31:0] adr, input bit w, input bit hw);
      bus.i_read_adr = adr; bus.i_read_w = w; bus.i_read_hw = hw; bus.i_read_req = 1;
   endtask
   task automatic req_dr(input logic [31:0] adr, input bit w, input bit hw);
      bus.d_read_adr = adr; bus.d_read_w = w; bus.d_read_hw = hw; bus.d_read_req = 1;
   endtask
   task automatic req_dw(input logic [31:0] adr, input bit w, input bit hw, input logic [31:0] d);
      bus.d_write_adr = adr; bus.d_write_w = w; bus.d_write_hw = hw; bus.d_write_data = d;
      bus.d_write_req = 1;
   endtask
   task automatic req_ur(input logic [31:0] adr);
      bus.u_read_adr = adr; bus.u_read_w = 1; bus.u_read_req = 1;
   endtask
   task automatic req_uw(input logic [31:0] adr, input logic [31:0] d);
      bus.u_write_adr = adr; bus.u_write_w = 1; bus.u_write_data = d; bus.u_write_req = 1;
   endtask

   task automatic wait_req(output bit ok);
      int n;
      n = 0;
      while (!(bus.read_req || bus.write_req) && n < 40) begin
         tick();
         n++;
      end
      ok = (n < 40);
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_req: no memory request within 40 cycles at cycle %0d", cyc);
      end
   endtask

   task automatic serve(input int lat, input bit wrong_first);
      bit ok, wr;
      wait_req(ok);
      if (ok) begin
         wr = bus.write_req;
         tick();
         for (int i = 0; i < lat; i++) begin
            if (wrong_first && i == 0) begin
               if (wr) bus.read_valid = 1; else bus.write_finish = 1;
            end
            tick();
         end
         if (wr) bus.write_finish = 1; else bus.read_valid = 1;
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b, t0;
      bit ok;
      bus.i_read_req = 0; bus.i_read_w = 0; bus.i_read_hw = 0; bus.i_read_adr = 0;
      bus.d_read_req = 0; bus.d_write_req = 0; bus.d_read_w = 0; bus.d_read_hw = 0;
      bus.d_write_w = 0; bus.d_write_hw = 0; bus.d_read_adr = 0; bus.d_write_adr = 0;
      bus.d_write_data = 0; bus.u_read_req = 0; bus.u_write_req = 0; bus.u_read_w = 0;
      bus.u_write_w = 0; bus.u_read_adr = 0; bus.u_write_adr = 0; bus.u_write_data = 0;
      bus.read_valid = 0; bus.write_finish = 0;
      tick(); tick(); tick();
      rst_n = 1;
      tick();

      // single I fetch on an idle arbiter
      b = obs.size(); t0 = cyc;
      req_i(32'h100, 1, 0);
      tick();
      serve(2, 0);
      chk("t1_adr", ob(b).adr, 32'h100);
      chk("t1_latency", ob(b).cyc - t0, 32'd2);

      // U read moves the pointer back to I; a stray write_finish during WAIT_R is ignored
      req_ur(32'h3100);
      tick();
      serve(1, 1);

      // three sources at once from pointer I
      b = obs.size();
      req_i(32'h1000, 1, 0);
      req_dw(32'h2000, 1, 0, 32'h11223344);
      req_ur(32'h3000);
      tick();
      serve(0, 0); serve(0, 0); serve(0, 0);
      tick(); tick();
      chk("t2_count", obs.size() - b, 32'd3);
      chk("t2_first", ob(b).adr, 32'h1000);
      chk("t2_second", ob(b + 1).adr, 32'h2000);
      chk("t2_third", ob(b + 2).adr, 32'h3000);

      // D write beats D read
      b = obs.size();
      req_dw(32'h200, 1, 0, 32'hA5A5A5A5);
      req_dr(32'h200, 0, 1);
      tick();
      serve(1, 0); serve(0, 0);
      chk("t3_first_wr", ob(b).wr, 32'd1);
      chk("t3_second_wr", ob(b + 1).wr, 32'd0);

      // continuous I fetches cannot starve a pending U write
      req_ur(32'h3200);
      tick();
      serve(0, 0);
      b = obs.size();
      hammer_i = 1;
      bus.i_read_w = 1; bus.i_read_hw = 0;
      req_i(32'h1100, 1, 0);
      req_uw(32'h4000, 32'hCAFEF00D);
      tick();
      serve(1, 0); serve(1, 0);
      hammer_i = 0;
      serve(0, 0);
      chk("t4_u_adr", ob(b + 1).adr, 32'h4000);
      chk("t4_u_wr", ob(b + 1).wr, 32'd1);

      // a second pulse on a pending slot is dropped; completions while idle are ignored
      b = obs.size();
      req_dr(32'h500, 1, 0);
      tick();
      req_dr(32'h600, 1, 0);
      tick();
      serve(0, 0);
      chk("t5_drop", ob(b).adr, 32'h500);
      tick();
      bus.read_valid = 1; bus.write_finish = 1;
      tick(); tick();

      // reset in WAIT_R aborts without a completion pulse
      req_i(32'h700, 1, 0);
      tick();
      wait_req(ok);
      tick(); tick();
      rst_n = 0;
      bus.read_valid = 1;
      #1;
      chk("t6_rst_valid", bus.i_read_valid, 32'd0);
      chk("t6_rst_busy", arb_busy, 32'd0);
      tick(); tick();
      rst_n = 1;
      tick();
      b = obs.size();
      req_i(32'h800, 0, 0);
      tick();
      serve(0, 0);
      chk("t6_after_rst", ob(b).adr, 32'h800);

`ifdef ARB_TIMEOUT_EN
      // no memory response: forced completion after TMO cycles in WAIT
      req_i(32'h900, 1, 0);
      tick();
      wait_req(ok);
      repeat (TMO + 4) tick();
      chk("t7_timeout_err", timeout_err, 32'd1);
      bus.read_valid = 1;
      tick(); tick();
`endif
      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
